// File: rtl/pc_stack_unit.sv
// Program counter with an integrated return-address stack and sticky fault flags.
// Define PC_REL_BRANCH_EN to enable the relative-branch adder for op 011.
module pc_stack_unit #(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int unsigned   INC_STEP  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [2:0]                     op,
  input  logic [AW-1:0]                  target,
  input  logic [AW-1:0]                  offset,
  input  logic                           err_clr,
  output logic [AW-1:0]                  pc_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int unsigned   CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [AW-1:0] STEP = AW'(INC_STEP);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_REL  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  op_e           op_w;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] top;
  logic          push;
  logic          ovf_set;
  logic          unf_set;
  logic          empty_w;
  logic          full_w;

  assign op_w     = op_e'(op);
  assign ret_addr = pc_q + STEP;
  assign empty_w  = (cnt_q == '0);
  assign full_w   = (cnt_q == CW'(RAS_DEPTH));

`ifndef PC_REL_BRANCH_EN
  logic unused_offset;
  assign unused_offset = ^offset;
`endif

  // Top-of-stack read: entry cnt_q-1, selected by compare to avoid an oversized index.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = ras_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op_w)
        OP_INC:  pc_d = ret_addr;
        OP_LOAD: pc_d = target;
`ifdef PC_REL_BRANCH_EN
        OP_REL:  pc_d = pc_q + offset;
`endif
        OP_CALL: begin
          pc_d = target;
          if (full_w) begin
            ovf_set = 1'b1;
          end else begin
            push  = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_RET: begin
          if (empty_w) begin
            pc_d    = ret_addr;
            unf_set = 1'b1;
          end else begin
            pc_d  = top;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_CLR:  pc_d = RESET_VEC;
        default: pc_d = pc_q;
      endcase
    end
    // A fault raised in the same cycle as err_clr must survive the clear.
    ovf_d = (ovf_q & ~err_clr) | ovf_set;
    unf_d = (unf_q & ~err_clr) | unf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        if (push && (cnt_q == CW'(i))) ras_q[i] <= ret_addr;
      end
    end
  end

  assign pc_addr   = pc_q;
  assign ras_count = cnt_q;
  assign ras_empty = empty_w;
  assign ras_full  = full_w;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed bench for pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [15:0] target;
  logic [15:0] offset;
  logic        err_clr;
  logic [15:0] pc_addr;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        err_ovf;
  logic        err_unf;

  pc_stack_unit #(
    .AW        (16),
    .RAS_DEPTH (DEPTH),
    .RESET_VEC (16'h0000),
    .INC_STEP  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .err_clr   (err_clr),
    .pc_addr   (pc_addr),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk [$];
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(pc_addr),   32'(m_pc));
    chk({tag, ".count"}, 32'(ras_count), m_stk.size());
    chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(ras_full),  32'(m_stk.size() == DEPTH));
    chk({tag, ".ovf"},   32'(err_ovf),   32'(m_ovf));
    chk({tag, ".unf"},   32'(err_unf),   32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update(input logic e, input logic [2:0] o, input logic [15:0] t,
                              input logic [15:0] off, input logic ec);
    logic ovf_s;
    logic unf_s;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (e) begin
      case (o)
        3'd1: m_pc = m_pc + 16'd1;
        3'd2: m_pc = t;
        3'd3: begin
`ifdef PC_REL_BRANCH_EN
          m_pc = m_pc + off;
`endif
        end
        3'd4: begin
          if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
          else ovf_s = 1'b1;
          m_pc = t;
        end
        3'd5: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc  = m_pc + 16'd1;
            unf_s = 1'b1;
          end
        end
        3'd6: m_pc = 16'h0000;
        default: ;
      endcase
    end
    m_ovf = (m_ovf && !ec) || ovf_s;
    m_unf = (m_unf && !ec) || unf_s;
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic [15:0] t,
                      input logic [15:0] off, input logic ec, input string tag);
    @(negedge clk);
    en = e; op = o; target = t; offset = off; err_clr = ec;
    @(posedge clk);
    #1;
    model_update(e, o, t, off, ec);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must settle before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    en = 1'b0; err_clr = 1'b0; op = 3'd0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; target = '0; offset = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Test 1: reset mid-cycle with pc 0x0042 and two entries stacked
    step(1, 3'd4, 16'h0010, 16'h0, 0, "t1.call0");
    step(1, 3'd4, 16'h0042, 16'h0, 0, "t1.call1");
    chk("t1.pc_pre", 32'(pc_addr), 32'h0042);
    async_reset("t1.rst");

    // Test 2
    step(1, 3'd1, 16'h0, 16'h0, 0, "t2.inc1");
    step(1, 3'd1, 16'h0, 16'h0, 0, "t2.inc2");
    step(1, 3'd1, 16'h0, 16'h0, 0, "t2.inc3");
    chk("t2.pc3", 32'(pc_addr), 32'h0003);
    step(1, 3'd2, 16'h1234, 16'h0, 0, "t2.load");
    step(1, 3'd1, 16'h0, 16'h0, 0, "t2.inc4");
    chk("t2.pc_final", 32'(pc_addr), 32'h1235);

    // Test 3
    step(1, 3'd2, 16'h0010, 16'h0, 0, "t3.load");
    step(1, 3'd4, 16'h0100, 16'h0, 0, "t3.call1");
    step(1, 3'd4, 16'h0200, 16'h0, 0, "t3.call2");
    step(1, 3'd5, 16'h0, 16'h0, 0, "t3.ret1");
    chk("t3.ret1_pc", 32'(pc_addr), 32'h0101);
    step(1, 3'd5, 16'h0, 16'h0, 0, "t3.ret2");
    chk("t3.ret2_pc", 32'(pc_addr), 32'h0011);

    // Test 4: overflow, unwind, underflow, clear
    for (int i = 0; i < 5; i++) step(1, 3'd4, 16'h0A00, 16'h0, 0, "t4.call");
    chk("t4.ovf", 32'(err_ovf), 32'd1);
    chk("t4.count", 32'(ras_count), 32'd4);
    for (int i = 0; i < 5; i++) step(1, 3'd5, 16'h0, 16'h0, 0, "t4.ret");
    chk("t4.unf", 32'(err_unf), 32'd1);
    step(1, 3'd0, 16'h0, 16'h0, 1, "t4.clr");
    // Clear and a new fault together: set wins
    step(1, 3'd5, 16'h0, 16'h0, 1, "t4.clr_vs_unf");

    // Test 5: relative branch and wrap-around
    step(1, 3'd2, 16'h0008, 16'h0, 0, "t5.load");
    step(1, 3'd3, 16'h0, 16'hFFFC, 0, "t5.rel_neg");
    step(1, 3'd2, 16'hFFFE, 16'h0, 0, "t5.load2");
    step(1, 3'd3, 16'h0, 16'h0004, 0, "t5.rel_wrap");
    step(1, 3'd2, 16'hFFFF, 16'h0, 0, "t5.load3");
    step(1, 3'd1, 16'h0, 16'h0, 0, "t5.inc_wrap");
    chk("t5.wrap_pc", 32'(pc_addr), 32'h0000);

    // Test 6: stall holds everything, err_clr still honoured
    step(1, 3'd4, 16'h0300, 16'h0, 0, "t6.pre_call");
    step(1, 3'd5, 16'h0, 16'h0, 0, "t6.pre_ret");
    step(1, 3'd5, 16'h0, 16'h0, 0, "t6.pre_unf");
    for (int i = 0; i < 3; i++) step(0, 3'd4, 16'h0300, 16'h0, 0, "t6.stall");
    step(0, 3'd4, 16'h0300, 16'h0, 1, "t6.stall_clr");
    step(1, 3'd4, 16'h0300, 16'h0, 0, "t6.go");
    chk("t6.go_pc", 32'(pc_addr), 32'h0300);
    step(1, 3'd6, 16'h0, 16'h0, 0, "t6.clr_op");

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset("rnd.rst");
      else step($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
                16'($urandom), 16'($urandom), $urandom_range(0, 9) == 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
